// File: rtl/matrix_scan_ctrl_pkg.sv
// Shared sizing helpers and types for the dot-matrix scan blocks.
// Pure declarations: no timing and no handshake of its own.
package matrix_scan_ctrl_pkg;

  localparam int DEF_ROWS = 7;
  localparam int DEF_COLS = 5;

  // Never returns 0, so single-entry counters still get a 1-bit register.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  // Prescaler view of the current column slot.
  typedef struct packed {
    logic tick;       // last cycle of the slot
    logic blank_nxt;  // next cycle falls inside the anti-ghost window
  } tick_t;

endpackage

// File: rtl/matrix_scan_ctrl_if.sv
// Message side and pin side of the column scanner bundled as one port.
// Inputs are sampled every clock; the pin side is free-running with no backpressure.
interface matrix_scan_ctrl_if
  import matrix_scan_ctrl_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int COLS     = DEF_COLS,
  parameter int MSG_COLS = DEF_COLS
);
  localparam int SW = clog2(COLS);

  logic [ROWS*MSG_COLS-1:0] data_in;
  logic                     load;
  logic                     scroll_en;
  logic                     blank;
  logic [ROWS-1:0]          row_out;
  logic [COLS-1:0]          col_en;
  logic [SW-1:0]            col_sel;
  logic                     frame_done;

  modport master (
    output data_in, load, scroll_en, blank,
    input  row_out, col_en, col_sel, frame_done
  );

  modport slave (
    input  data_in, load, scroll_en, blank,
    output row_out, col_en, col_sel, frame_done
  );

endinterface

// File: rtl/matrix_scan_ctrl_tick_gen.sv
// Column-slot prescaler: counts 0..DIV-1 and flags the slot end and the blank window.
// Outputs are combinational from the count register; no backpressure.
module scan_tick_gen
  import matrix_scan_ctrl_pkg::*;
#(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 1
) (
  input  logic  clk,
  input  logic  reset_n,
  output tick_t tk
);
  localparam int            CW      = clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // blank_nxt looks one cycle ahead because the pin stage behind it is registered.
  always_comb begin
    tk.tick      = (cnt_q == CNT_MAX);
    cnt_d        = tk.tick ? '0 : cnt_q + 1'b1;
    tk.blank_nxt = (int'(cnt_d) < BLANK_CYC);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Time-multiplexed LED column scanner with double-buffered message, blanking and scroll.
// Pins follow the slot counter by one registered cycle; no backpressure, load is a strobe.
module matrix_scan_ctrl
  import matrix_scan_ctrl_pkg::*;
#(
  parameter int ROWS          = DEF_ROWS,
  parameter int COLS          = DEF_COLS,
  parameter int MSG_COLS      = DEF_COLS,
  parameter int DIV           = 50000,
  parameter int BLANK_CYC     = 1,
  parameter int SCROLL_FRAMES = 25,
  parameter int ACTIVE_LOW    = 0
) (
  input logic               clk,
  input logic               reset_n,
  matrix_scan_ctrl_if.slave bus
);
  localparam int SW = clog2(COLS);
  localparam int OW = clog2(MSG_COLS);
  localparam int FW = clog2(SCROLL_FRAMES);
  localparam int IW = OW + 1;

  localparam logic [SW-1:0] SEL_MAX = SW'(COLS - 1);
  localparam logic [OW-1:0] OFS_MAX = OW'(MSG_COLS - 1);
  localparam logic [FW-1:0] FRM_MAX = FW'(SCROLL_FRAMES - 1);
  localparam logic [IW-1:0] MSG_N   = IW'(MSG_COLS);

  typedef logic [MSG_COLS-1:0][ROWS-1:0] msg_t;

  tick_t tk;

  logic [SW-1:0]   sel_q, sel_d;
  logic [OW-1:0]   ofs_q, ofs_d;
  logic [FW-1:0]   frm_q, frm_d;
  msg_t            disp_q, disp_d;
  msg_t            pend_q, pend_d;
  logic            pend_vld_q, pend_vld_d;
  logic [ROWS-1:0] row_q, row_d;
  logic [COLS-1:0] col_q, col_d;
  logic            done_q;
  logic            boundary;
  logic [IW-1:0]   idx_sum;
  logic [OW-1:0]   idx;

  scan_tick_gen #(
    .DIV       (DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tk      (tk)
  );

  always_comb begin
    boundary   = tk.tick && (sel_q == SEL_MAX);
    sel_d      = sel_q;
    ofs_d      = ofs_q;
    frm_d      = frm_q;
    disp_d     = disp_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;

    if (tk.tick) sel_d = boundary ? '0 : sel_q + 1'b1;

    // A pending message restarts the window and wins over a due scroll step.
    if (boundary && pend_vld_q) begin
      disp_d     = pend_q;
      ofs_d      = '0;
      frm_d      = '0;
      pend_vld_d = 1'b0;
    end else if (boundary && bus.scroll_en) begin
      if (frm_q == FRM_MAX) begin
        frm_d = '0;
        ofs_d = (ofs_q == OFS_MAX) ? '0 : ofs_q + 1'b1;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end

    // Evaluated after the apply so a load on the boundary waits for the next frame.
    if (bus.load) begin
      pend_d     = bus.data_in;
      pend_vld_d = 1'b1;
    end

    // Pin stage is fed from next-state values so it lines up with the new col_sel.
    idx_sum = {1'b0, ofs_d} + IW'(sel_d);
    if (idx_sum >= MSG_N) idx_sum = idx_sum - MSG_N;
    idx = idx_sum[OW-1:0];

    row_d = bus.blank ? '0 : disp_d[idx];
    col_d = '0;
    if (!bus.blank && !tk.blank_nxt) col_d[sel_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q      <= '0;
      ofs_q      <= '0;
      frm_q      <= '0;
      disp_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      ofs_q      <= ofs_d;
      frm_q      <= frm_d;
      disp_q     <= disp_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      row_q      <= row_d;
      col_q      <= col_d;
      done_q     <= boundary;
    end
  end

  assign bus.row_out    = (ACTIVE_LOW != 0) ? ~row_q : row_q;
  assign bus.col_en     = (ACTIVE_LOW != 0) ? ~col_q : col_q;
  assign bus.col_sel    = sel_q;
  assign bus.frame_done = done_q;

endmodule
